fifo_write_arbiter: RTL

- Round-robin arbiter that shares the write port of the async FIFO write side among NREQ requesters in the write clock domain.
- Grants burst ownership to one requester, forwards its data beats as signal_write/write_data, stalls on full, and releases on last beat, burst limit or abort.
- Sits directly in front of the FIFO write-pointer/full logic; its signal_write feeds that block's write enable.

---
 rtl/fifo_write_arbiter_pkg.sv | 10 +
 rtl/fifo_write_arbiter_rr_pick.sv | 17 +
 rtl/fifo_write_arbiter.sv | 62 ++++++
 3 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_write_arbiter_pkg: shared state encoding and width helper for the write arbiter
package fifo_write_arbiter_pkg;
  typedef enum logic {ST_IDLE, ST_OWN} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit after last_owner
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_owner,
  output logic         found,
  output logic [W-1:0] index
);
  always_comb begin
    found = |req;
    index = '0;
    for (int i = N; i >= 1; i--)
      if (req[(int'(last_owner) + i) % N]) index = W'((int'(last_owner) + i) % N);
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing the async FIFO write port
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DSIZE = 8,
  parameter int MAX_BURST = 8,
  localparam int OWNW = clog2(NREQ),
  localparam int CNTW = clog2(MAX_BURST) + 1
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  input  logic                  full,
  output logic                  signal_write,
  output logic [DSIZE-1:0]      write_data,
  output logic [OWNW-1:0]       owner,
  output logic                  busy,
  output logic                  err_abort
);
  state_t state, state_nxt;
  logic [OWNW-1:0] last_owner, pick_idx;
  logic [CNTW-1:0] beat_cnt;
  logic pick_found, accept, rel, abort;
  rr_pick #(.N(NREQ), .W(OWNW)) u_pick (
    .req(req),
    .last_owner(last_owner),
    .found(pick_found),
    .index(pick_idx)
  );
  always_ff @(posedge wclk) state <= rst ? ST_IDLE : state_nxt;
  always_comb begin
    accept = state == ST_OWN && req[owner] && !full;
    rel = accept && (req_last[owner] || beat_cnt == CNTW'(MAX_BURST - 1));
    // a full stall does not hide a dropped request
    abort = state == ST_OWN && !req[owner];
    state_nxt = state == ST_IDLE ? (pick_found ? ST_OWN : ST_IDLE) : (rel || abort ? ST_IDLE : ST_OWN);
    signal_write = accept;
    grant = accept ? NREQ'(1) << owner : '0;
    write_data = req_data[owner*DSIZE +: DSIZE];
    busy = state == ST_OWN;
  end
  always_ff @(posedge wclk) begin
    if (rst) begin
      owner <= '0;
      last_owner <= OWNW'(NREQ - 1);
      beat_cnt <= '0;
      err_abort <= 1'b0;
    end else begin
      err_abort <= abort;
      if (state == ST_IDLE && pick_found) begin
        owner <= pick_idx;
        beat_cnt <= '0;
      end
      if (accept) beat_cnt <= beat_cnt + CNTW'(1);
      if (rel || abort) last_owner <= owner;
    end
  end
endmodule
